// File: rtl/cim_tile_sequencer.sv
// -----------------------------------------------------------------------------
// cim_tile_sequencer
//
// Job-level controller for the 36-lane CIM macro. It accepts a job of
// job_tiles+1 tiles. For each tile it fetches the operands from the operand
// buffer (LOAD), then runs the macro with DataValid held high until CIM_done
// arrives or the run times out (RUN). Between two tiles it inserts a single
// idle cycle (GAP) so the macro can re-arm. In INT mode the 22-bit per-tile
// results are sign-extended and summed into an ACC_W-bit partial sum. In FP
// mode the result is the FP word of the last completed tile. The result is
// returned over a valid/ready handshake (OUT).
//
// Handshakes (both use strict valid/ready semantics):
//   job: a transfer happens on a rising edge where job_valid && job_ready.
//        job_ready is high only in IDLE. A request seen while busy is
//        dropped, not queued. job_valid may be raised with no condition.
//   res: a transfer happens on a rising edge where res_valid && res_ready.
//        res_valid and all res_* fields hold steady until that edge.
//
// Ports:
//   clk, RSTN          clock (rising edge), asynchronous active-low reset
//   job_valid/ready    job request handshake
//   job_tiles          number of tiles minus 1
//   job_infp           0 = INT, 1 = FP
//   job_base_addr      buffer address of tile 0
//   mem_rd_en          one-cycle operand fetch strobe (first LOAD cycle)
//   mem_rd_addr        job_base_addr + tile index, wraps modulo 2^ADDR_W
//   cim_datavalid      DataValid to the macro (high in RUN)
//   cim_infp           InFp to the macro, latched job mode during the job
//   cim_done           CIM_done from the macro (sampled in RUN only)
//   cim_int_in         signed 22-bit FinalOut_INT
//   cim_fp_in          {FP3,FP2,FP1,FP0}
//   res_valid/ready    result handshake
//   res_int            signed accumulated INT sum (0 in FP mode)
//   res_fp             FP word of the last completed tile (0 in INT mode)
//   res_err            job aborted on a run timeout
//   busy               controller is not idle
//   state_dbg          current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module cim_tile_sequencer #(
    parameter int TILE_W   = 4,
    parameter int ADDR_W   = 10,
    parameter int LOAD_LAT = 2,
    parameter int TIMEOUT  = 64,
    parameter int ACC_W    = 32
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [TILE_W-1:0] job_tiles,
    input  logic              job_infp,
    input  logic [ADDR_W-1:0] job_base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              cim_datavalid,
    output logic              cim_infp,
    input  logic              cim_done,
    input  logic [21:0]       cim_int_in,
    input  logic [31:0]       cim_fp_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_int,
    output logic [31:0]       res_fp,
    output logic              res_err,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    localparam int INT_W = 22;
    localparam int LC_W  = $clog2(LOAD_LAT + 1);
    localparam int RC_W  = $clog2(TIMEOUT);
    localparam logic [LC_W-1:0] LOAD_LAST = LC_W'(LOAD_LAT - 1);
    localparam logic [RC_W-1:0] RUN_LAST  = RC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_GAP  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [TILE_W-1:0] tiles_q;
    logic [TILE_W-1:0] tile_idx;
    logic [ADDR_W-1:0] base_q;
    logic              infp_q;
    logic [LC_W-1:0]   load_cnt;
    logic [RC_W-1:0]   run_cnt;
    logic [ACC_W-1:0]  acc;
    logic [31:0]       fp_q;
    logic              err_q;

    logic last_tile;
    logic run_timeout;

    assign last_tile   = (tile_idx == tiles_q);
    assign run_timeout = (run_cnt == RUN_LAST);

    // State register
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A done in the timeout cycle is a normal completion.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (job_valid) state_nxt = S_LOAD;
            S_LOAD: if (load_cnt == LOAD_LAST) state_nxt = S_RUN;
            S_RUN: begin
                if (cim_done) begin
                    state_nxt = last_tile ? S_OUT : S_GAP;
                end else if (run_timeout) begin
                    state_nxt = S_OUT;
                end
            end
            S_GAP:  state_nxt = S_LOAD;
            S_OUT:  if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job fields, counters and result registers
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            tiles_q  <= '0;
            tile_idx <= '0;
            base_q   <= '0;
            infp_q   <= 1'b0;
            load_cnt <= '0;
            run_cnt  <= '0;
            acc      <= '0;
            fp_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        tiles_q  <= job_tiles;
                        infp_q   <= job_infp;
                        base_q   <= job_base_addr;
                        tile_idx <= '0;
                        acc      <= '0;
                        fp_q     <= '0;
                        err_q    <= 1'b0;
                        load_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    load_cnt <= load_cnt + 1'b1;
                    run_cnt  <= '0;
                end
                S_RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    if (cim_done) begin
                        if (infp_q) begin
                            fp_q <= cim_fp_in;
                        end else begin
                            acc <= acc + {{(ACC_W-INT_W){cim_int_in[INT_W-1]}}, cim_int_in};
                        end
                        if (!last_tile) tile_idx <= tile_idx + 1'b1;
                    end else if (run_timeout) begin
                        err_q <= 1'b1;
                    end
                end
                S_GAP: begin
                    load_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state and data only. The res_* fields
    // read as zero outside OUT so nothing stale leaks between jobs.
    assign job_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign mem_rd_en     = (state == S_LOAD) && (load_cnt == '0);
    assign mem_rd_addr   = base_q + ADDR_W'(tile_idx);
    assign cim_datavalid = (state == S_RUN);
    assign cim_infp      = infp_q && (state != S_IDLE);
    assign res_valid     = (state == S_OUT);
    assign res_int       = (state == S_OUT) ? acc : '0;
    assign res_fp        = (state == S_OUT) ? fp_q : '0;
    assign res_err       = (state == S_OUT) && err_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_cim_tile_sequencer.sv
`timescale 1ns/1ps
module tb_cim_tile_sequencer;

    localparam int TILE_W   = 4;
    localparam int ADDR_W   = 10;
    localparam int LOAD_LAT = 2;
    localparam int TIMEOUT  = 64;
    localparam int ACC_W    = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic RSTN;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic              job_valid;
    logic              job_ready;
    logic [TILE_W-1:0] job_tiles;
    logic              job_infp;
    logic [ADDR_W-1:0] job_base_addr;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              cim_datavalid;
    logic              cim_infp;
    logic              cim_done;
    logic [21:0]       cim_int_in;
    logic [31:0]       cim_fp_in;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_int;
    logic [31:0]       res_fp;
    logic              res_err;
    logic              busy;
    logic [2:0]        state_dbg;

    cim_tile_sequencer #(
        .TILE_W(TILE_W), .ADDR_W(ADDR_W), .LOAD_LAT(LOAD_LAT),
        .TIMEOUT(TIMEOUT), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .RSTN(RSTN),
        .job_valid(job_valid), .job_ready(job_ready), .job_tiles(job_tiles),
        .job_infp(job_infp), .job_base_addr(job_base_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .cim_datavalid(cim_datavalid), .cim_infp(cim_infp),
        .cim_done(cim_done), .cim_int_in(cim_int_in), .cim_fp_in(cim_fp_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_int(res_int),
        .res_fp(res_fp), .res_err(res_err), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // Per-tile plan for the macro model: cycles into RUN before done
    // (>= TIMEOUT means done is never raised), and the tile's results.
    int          t_delay [16];
    logic [21:0] t_int   [16];
    logic [31:0] t_fp    [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_dv"}, cim_datavalid, 0);
        chk({tag, "_infp"}, cim_infp, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_int"}, res_int, 0);
        chk({tag, "_res_fp"}, res_fp, 0);
        chk({tag, "_res_err"}, res_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_job_ready"}, job_ready, 1);
        chk({tag, "_state"}, state_dbg, 0);
    endtask

    // Drives one job and plays the macro. Expected results are built from
    // the job rules: address = base + tile mod 2^ADDR_W, INT sum is the
    // sign-extended sum mod 2^ACC_W, FP result is the last done tile, a
    // tile without done for TIMEOUT cycles ends the job with an error.
    // abort_tile >= 0 pulls reset two cycles into RUN of that tile.
    task automatic run_job(input int tiles, input bit infp, input int base,
                           input int rdy_wait, input bit noise, input int abort_tile);
        longint      sum;
        logic [31:0] fp_exp;
        bit          err_exp;
        int          run_len;
        logic [63:0] sum_v;

        sum = 0; fp_exp = '0; err_exp = 1'b0;
        chk("idle_job_ready", job_ready, 1);
        job_valid     = 1'b1;
        job_tiles     = TILE_W'(tiles);
        job_infp      = infp;
        job_base_addr = ADDR_W'(base);
        step();
        // scramble the request fields: the DUT must use its latched copy
        job_valid     = 1'b0;
        job_tiles     = TILE_W'($urandom);
        job_infp      = ~infp;
        job_base_addr = ADDR_W'($urandom);
        chk("accept_busy", busy, 1);
        chk("accept_job_ready", job_ready, 0);

        for (int t = 0; t <= tiles; t++) begin
            for (int c = 0; c < LOAD_LAT; c++) begin
                chk("load_rd_en", mem_rd_en, c == 0);
                chk("load_addr", mem_rd_addr, (base + t) % (1 << ADDR_W));
                chk("load_dv", cim_datavalid, 0);
                chk("load_infp", cim_infp, infp);
                chk("load_res_valid", res_valid, 0);
                cim_done   = noise;
                cim_int_in = 22'($urandom);
                cim_fp_in  = $urandom;
                step();
            end
            cim_done = 1'b0;
            run_len = (t_delay[t] < TIMEOUT) ? t_delay[t] + 1 : TIMEOUT;
            for (int k = 0; k < run_len; k++) begin
                chk("run_dv", cim_datavalid, 1);
                chk("run_infp", cim_infp, infp);
                chk("run_res_valid", res_valid, 0);
                if (abort_tile == t && k == 2) begin
                    RSTN = 1'b0;
                    #1;
                    chk_reset_outputs("midjob_rst");
                    cim_done = 1'b0;
                    @(negedge clk);
                    RSTN = 1'b1;
                    step();
                    chk("post_rst_job_ready", job_ready, 1);
                    chk("post_rst_busy", busy, 0);
                    return;
                end
                if (k == t_delay[t]) begin
                    cim_done   = 1'b1;
                    cim_int_in = t_int[t];
                    cim_fp_in  = t_fp[t];
                end else begin
                    cim_done   = 1'b0;
                    cim_int_in = 22'($urandom);
                    cim_fp_in  = $urandom;
                end
                step();
            end
            cim_done = 1'b0;
            if (t_delay[t] >= TIMEOUT) begin
                err_exp = 1'b1;
                break;
            end
            if (infp) fp_exp = t_fp[t];
            else      sum += longint'($signed(t_int[t]));
            if (t < tiles) begin
                chk("gap_dv", cim_datavalid, 0);
                chk("gap_rd_en", mem_rd_en, 0);
                chk("gap_res_valid", res_valid, 0);
                cim_done = noise;
                step();
                cim_done = 1'b0;
            end
        end

        sum_v = 64'(sum);
        for (int w = 0; w <= rdy_wait; w++) begin
            chk("out_res_valid", res_valid, 1);
            chk("out_res_int", res_int, infp ? 0 : sum_v[ACC_W-1:0]);
            chk("out_res_fp", res_fp, infp ? fp_exp : 32'h0);
            chk("out_res_err", res_err, err_exp);
            chk("out_dv", cim_datavalid, 0);
            chk("out_job_ready", job_ready, 0);
            chk("out_infp", cim_infp, infp);
            res_ready = (w == rdy_wait);
            job_valid = (w == rdy_wait) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        // job_valid was high in the handshake cycle; it must not be taken
        res_ready = 1'b0;
        chk("hs_res_valid", res_valid, 0);
        chk("hs_job_ready", job_ready, 1);
        chk("hs_busy", busy, 0);
        job_valid = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        RSTN = 1'b0;
        job_valid = 1'b0; job_tiles = '0; job_infp = 1'b0; job_base_addr = '0;
        cim_done = 1'b0; cim_int_in = '0; cim_fp_in = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        RSTN = 1'b1;
        step();

        // 1: single INT tile, -5, done 8 cycles into RUN
        t_delay[0] = 8; t_int[0] = 22'h3FFFFB; t_fp[0] = 32'hDEAD0001;
        run_job(0, 1'b0, 10'h123, 0, 1'b0, -1);

        // 2: three INT tiles from 0x3FE, address wrap, noise on done outside RUN
        t_delay[0] = 3; t_int[0] = 22'd100;
        t_delay[1] = 0; t_int[1] = 22'h3FFED4;   // -300
        t_delay[2] = 5; t_int[2] = 22'h1FFFFF;   // 2097151
        run_job(2, 1'b0, 10'h3FE, 0, 1'b1, -1);

        // 3: two FP tiles
        t_delay[0] = 4; t_fp[0] = 32'h11223344; t_int[0] = 22'h00ABC;
        t_delay[1] = 6; t_fp[1] = 32'hA5B6C7D8; t_int[1] = 22'h01234;
        run_job(1, 1'b1, 10'h040, 1, 1'b0, -1);

        // 4: done never raised, then a normal job
        t_delay[0] = TIMEOUT; t_int[0] = 22'd77;
        run_job(0, 1'b0, 10'h000, 0, 1'b0, -1);
        t_delay[0] = 2; t_int[0] = 22'd9;
        run_job(0, 1'b0, 10'h001, 0, 1'b0, -1);

        // 5: consumer stalls for 10 cycles
        t_delay[0] = 1; t_int[0] = 22'h200000;   // most negative
        run_job(0, 1'b0, 10'h2AA, 10, 1'b0, -1);

        // 6: reset in RUN of tile 1 of 3, then done in the timeout cycle
        t_delay[0] = 1; t_delay[1] = 20; t_delay[2] = 1;
        run_job(2, 1'b0, 10'h100, 0, 1'b0, 1);
        t_delay[0] = TIMEOUT - 1; t_int[0] = 22'd1234;
        run_job(0, 1'b0, 10'h010, 0, 1'b0, -1);

        // random jobs
        for (int j = 0; j < 20; j++) begin
            int tiles;
            tiles = $urandom_range(0, 3);
            for (int t = 0; t <= tiles; t++) begin
                int r;
                r = $urandom_range(0, 9);
                t_delay[t] = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 12);
                t_int[t]   = 22'($urandom);
                t_fp[t]    = $urandom;
            end
            run_job(tiles, 1'($urandom_range(0, 1)), $urandom_range(0, 1023),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bounded run time
    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
